// File: rtl/kmkz_dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states,
// error read value and the read-timeout counter width.
package kmkz_dmem_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE      = 3'd0,
        ARB_CORE_RD   = 3'd1,
        ARB_DBG_ISSUE = 3'd2,
        ARB_DBG_RD    = 3'd3,
        ARB_DBG_DONE  = 3'd4
    } arb_state_e;

    localparam logic [31:0] ARB_ERR_DATA = 32'hFFFF_FFFF;
    localparam int          ARB_TMO_W    = 10;

endpackage

// File: rtl/kmkz_arb_timeout.sv
// Read-wait timeout: clearable up-counter with terminal-count flag.
// Ports: clk_i, rst_i (async, active-low), clr, en -> tc.
module kmkz_arb_timeout
    import kmkz_dmem_arbiter_pkg::*;
#(
    parameter int LIMIT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [ARB_TMO_W-1:0] cnt;

    assign tc = (cnt == ARB_TMO_W'(LIMIT - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + ARB_TMO_W'(1);
        end
    end

endmodule

// File: rtl/kmkz_dmem_arbiter.sv
// Data-memory arbiter between the exec load/store port (c_*) and a
// debug master (dbg_*); drives the memory bus (m_*). Core passes through.
module kmkz_dmem_arbiter
    import kmkz_dmem_arbiter_pkg::*;
#(
    parameter int DBG_STARVE_MAX = 8,
    parameter int RD_TIMEOUT     = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] c_addr_i,
    input  logic [31:0] c_wdata_i,
    input  logic [3:0]  c_sel_i,
    input  logic        c_load_i,
    input  logic        c_store_i,
    output logic        c_ready_o,
    output logic [31:0] c_rdata_o,
    output logic        c_rvalid_o,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic [3:0]  dbg_sel_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_err_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_sel_o,
    output logic        m_load_o,
    output logic        m_store_o,
    input  logic        m_ready_i,
    input  logic [31:0] m_rdata_i,
    input  logic        m_rvalid_i
);

    localparam logic [7:0] STARVE_MAX = 8'(DBG_STARVE_MAX);

    arb_state_e  state, state_nxt;
    logic [7:0]  starve_cnt;
    logic        force_dbg, core_acc;
    logic        dbg_grant, starve_inc;
    logic        rd_tc, rd_abort;
    logic        dbg_we_q;
    logic [31:0] dbg_addr_q, dbg_wdata_q;
    logic [3:0]  dbg_sel_q;

    // Debug has lost too many slots: hold the core off for one slot.
    assign force_dbg = (starve_cnt == STARVE_MAX) && dbg_req_i;
    assign c_ready_o = (state == ARB_IDLE) && m_ready_i && !force_dbg;
    assign core_acc  = c_ready_o && (c_load_i || c_store_i);

    assign dbg_grant  = (state == ARB_IDLE) && (state_nxt == ARB_DBG_ISSUE);
    assign starve_inc = (state == ARB_IDLE) && core_acc && dbg_req_i
                        && (starve_cnt != STARVE_MAX);
    assign rd_abort   = (state == ARB_DBG_RD) && !m_rvalid_i && rd_tc;
    assign dbg_ack_o  = (state == ARB_DBG_DONE);

    kmkz_arb_timeout #(
        .LIMIT (RD_TIMEOUT)
    ) u_tmo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (state_nxt != state),
        .en    ((state == ARB_CORE_RD) || (state == ARB_DBG_RD)),
        .tc    (rd_tc)
    );

    always_comb begin
        state_nxt  = state;
        m_addr_o   = c_addr_i;
        m_wdata_o  = c_wdata_i;
        m_sel_o    = c_sel_i;
        m_load_o   = 1'b0;
        m_store_o  = 1'b0;
        c_rvalid_o = 1'b0;
        c_rdata_o  = m_rdata_i;
        unique case (state)
            ARB_IDLE: begin
                m_load_o  = c_load_i;
                m_store_o = c_store_i;
                if (core_acc && c_load_i) begin
                    state_nxt = ARB_CORE_RD;
                end else if (dbg_req_i && !core_acc) begin
                    state_nxt = ARB_DBG_ISSUE;
                end
            end
            ARB_CORE_RD: begin
                if (m_rvalid_i) begin
                    c_rvalid_o = 1'b1;
                    state_nxt  = ARB_IDLE;
                end else if (rd_tc) begin
                    c_rvalid_o = 1'b1;
                    c_rdata_o  = ARB_ERR_DATA;
                    state_nxt  = ARB_IDLE;
                end
            end
            ARB_DBG_ISSUE: begin
                m_addr_o  = dbg_addr_q;
                m_wdata_o = dbg_wdata_q;
                m_sel_o   = dbg_sel_q;
                m_load_o  = !dbg_we_q;
                m_store_o = dbg_we_q;
                if (m_ready_i) begin
                    state_nxt = dbg_we_q ? ARB_DBG_DONE : ARB_DBG_RD;
                end
            end
            ARB_DBG_RD: begin
                if (m_rvalid_i || rd_tc) begin
                    state_nxt = ARB_DBG_DONE;
                end
            end
            ARB_DBG_DONE: begin
                state_nxt = ARB_IDLE;
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= ARB_IDLE;
            starve_cnt  <= '0;
            dbg_we_q    <= 1'b0;
            dbg_addr_q  <= '0;
            dbg_wdata_q <= '0;
            dbg_sel_q   <= '0;
            dbg_rdata_o <= '0;
            dbg_err_o   <= 1'b0;
        end else begin
            state     <= state_nxt;
            // Set only for the single DBG_DONE cycle that follows.
            dbg_err_o <= rd_abort;
            if (dbg_grant) begin
                dbg_we_q    <= dbg_we_i;
                dbg_addr_q  <= dbg_addr_i;
                dbg_wdata_q <= dbg_wdata_i;
                dbg_sel_q   <= dbg_sel_i;
                starve_cnt  <= '0;
            end else if (starve_inc) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
            if (state == ARB_DBG_RD) begin
                if (m_rvalid_i) begin
                    dbg_rdata_o <= m_rdata_i;
                end else if (rd_tc) begin
                    dbg_rdata_o <= ARB_ERR_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_kmkz_dmem_arbiter.sv
// Scoreboard bench for kmkz_dmem_arbiter: directed cases then a
// randomized core/debug mix against a behavioural memory model.
module tb_kmkz_dmem_arbiter;

    localparam int SMAX  = 8;
    localparam int TMO   = 64;
    localparam int BOUND = 400;

    typedef struct {
        bit          wr;
        bit          err;
        logic [31:0] data;
    } dexp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] c_addr_i, c_wdata_i;
    logic [3:0]  c_sel_i;
    logic        c_load_i, c_store_i;
    logic        c_ready_o, c_rvalid_o;
    logic [31:0] c_rdata_o;
    logic        dbg_req_i, dbg_we_i;
    logic [31:0] dbg_addr_i, dbg_wdata_i;
    logic [3:0]  dbg_sel_i;
    logic        dbg_ack_o, dbg_err_o;
    logic [31:0] dbg_rdata_o;
    logic [31:0] m_addr_o, m_wdata_o;
    logic [3:0]  m_sel_o;
    logic        m_load_o, m_store_o;
    logic        m_ready_i, m_rvalid_i;
    logic [31:0] m_rdata_i;

    always #5 clk = ~clk;

    kmkz_dmem_arbiter #(
        .DBG_STARVE_MAX (SMAX),
        .RD_TIMEOUT     (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .c_addr_i    (c_addr_i),
        .c_wdata_i   (c_wdata_i),
        .c_sel_i     (c_sel_i),
        .c_load_i    (c_load_i),
        .c_store_i   (c_store_i),
        .c_ready_o   (c_ready_o),
        .c_rdata_o   (c_rdata_o),
        .c_rvalid_o  (c_rvalid_o),
        .dbg_req_i   (dbg_req_i),
        .dbg_we_i    (dbg_we_i),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_wdata_i (dbg_wdata_i),
        .dbg_sel_i   (dbg_sel_i),
        .dbg_ack_o   (dbg_ack_o),
        .dbg_rdata_o (dbg_rdata_o),
        .dbg_err_o   (dbg_err_o),
        .m_addr_o    (m_addr_o),
        .m_wdata_o   (m_wdata_o),
        .m_sel_o     (m_sel_o),
        .m_load_o    (m_load_o),
        .m_store_o   (m_store_o),
        .m_ready_i   (m_ready_i),
        .m_rdata_i   (m_rdata_i),
        .m_rvalid_i  (m_rvalid_i)
    );

    int checks = 0;
    int passes = 0;
    int cyc_n  = 0;
    int core_rv = 0;
    int ack_cnt = 0;
    int ack_cyc = 0;
    bit dbg_acked = 0;

    logic [31:0] core_q[$];
    dexp_t       dbg_q[$];
    dexp_t       mon_de;

    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    bit mem_drop = 0;
    bit rnd_rdy  = 0;
    int lat_lo   = 1;
    int lat_hi   = 1;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got %0h, expected %0h", n, a, e);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic ref_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        ref_mem[a] = merge(ref_rd(a), d, s);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        env_mem[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Memory responder: single outstanding read, programmable latency.
    initial begin
        bit          a_ld, a_st;
        logic [31:0] a_addr, a_wd, pdata;
        logic [3:0]  a_sel;
        int          pend;
        m_ready_i  = 1'b1;
        m_rvalid_i = 1'b0;
        m_rdata_i  = '0;
        pend       = 0;
        pdata      = '0;
        forever begin
            @(negedge clk);
            a_ld   = m_load_o && m_ready_i;
            a_st   = m_store_o && m_ready_i;
            a_addr = {m_addr_o[31:2], 2'b00};
            a_wd   = m_wdata_o;
            a_sel  = m_sel_o;
            @(posedge clk);
            #1;
            m_rvalid_i = 1'b0;
            m_rdata_i  = $urandom;
            if (a_st) env_mem[a_addr] = merge(env_rd(a_addr), a_wd, a_sel);
            if (a_ld && !mem_drop) begin
                pend  = $urandom_range(lat_hi, lat_lo);
                pdata = env_rd(a_addr);
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    m_rvalid_i = 1'b1;
                    m_rdata_i  = pdata;
                end
            end
            m_ready_i = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: pops the scoreboards whenever the DUT presents a response.
    always @(negedge clk) begin
        if (rst_i) begin
            if (c_rvalid_o) begin
                core_rv++;
                if (core_q.size() == 0) chk("core_unexpected_rvalid", 1, 0);
                else chk("core_rdata", c_rdata_o, core_q.pop_front());
            end
            if (dbg_ack_o) begin
                ack_cnt++;
                ack_cyc   = cyc_n;
                dbg_acked = 1;
                if (dbg_q.size() == 0) begin
                    chk("dbg_unexpected_ack", 1, 0);
                end else begin
                    mon_de = dbg_q.pop_front();
                    chk("dbg_err", dbg_err_o, mon_de.err);
                    if (!mon_de.wr) chk("dbg_rdata", dbg_rdata_o, mon_de.data);
                end
            end
        end
    end

    task automatic dbg_xact(input bit we, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            input bit eerr, input logic [31:0] edata,
                            output int lat);
        dexp_t e;
        int    t0;
        e.wr = we;
        e.err = eerr;
        e.data = edata;
        dbg_q.push_back(e);
        if (we) ref_wr(a, d, s);
        dbg_acked   = 0;
        dbg_we_i    = we;
        dbg_addr_i  = a;
        dbg_wdata_i = d;
        dbg_sel_i   = s;
        dbg_req_i   = 1'b1;
        t0  = cyc_n;
        lat = -1;
        for (int i = 0; i < 300 && lat < 0; i++) begin
            cyc();
            if (dbg_acked) lat = ack_cyc - t0;
        end
        dbg_req_i = 1'b0;
        dbg_acked = 0;
        if (lat < 0) chk("dbg_ack_bound", 0, 1);
    endtask

    task automatic starve_round(input logic [31:0] da, output int grants);
        dexp_t       e;
        bit          hit;
        logic [31:0] d;
        preload(da, 32'h5EED_0000 + da);
        e.wr = 0;
        e.err = 0;
        e.data = 32'h5EED_0000 + da;
        dbg_q.push_back(e);
        dbg_acked  = 0;
        dbg_we_i   = 1'b0;
        dbg_addr_i = da;
        dbg_sel_i  = 4'hF;
        dbg_req_i  = 1'b1;
        grants = 0;
        hit    = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            #1;
            if (c_ready_o) begin
                d = $urandom;
                c_store_i = 1'b1;
                c_addr_i  = 32'(4 * i);
                c_wdata_i = d;
                c_sel_i   = 4'hF;
                ref_wr(32'(4 * i), d, 4'hF);
                grants++;
            end else begin
                hit = 1;
            end
            cyc();
            c_store_i = 1'b0;
        end
        #1;
        chk("starve_issue_load", m_load_o, 1);
        chk("starve_issue_addr", m_addr_o, da);
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            cyc();
            hit = dbg_acked;
        end
        if (!hit) chk("starve_ack_bound", 0, 1);
        dbg_req_i = 1'b0;
        dbg_acked = 0;
    endtask

    initial begin
        int    lat, g, rv0, ak0, dwait, r;
        bit    dact;
        dexp_t de;
        rst_i = 1'b0;
        c_addr_i = '0; c_wdata_i = '0; c_sel_i = '0;
        c_load_i = 1'b0; c_store_i = 1'b0;
        dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0;
        dbg_wdata_i = '0; dbg_sel_i = '0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_c_rvalid", c_rvalid_o, 0);
        chk("rst_dbg_ack", dbg_ack_o, 0);
        chk("rst_dbg_err", dbg_err_o, 0);
        chk("rst_dbg_rdata", dbg_rdata_o, 0);
        chk("rst_m_load", m_load_o, 0);
        chk("rst_m_store", m_store_o, 0);
        cyc();
        rst_i = 1'b1;
        cyc();

        c_store_i = 1'b1;
        c_addr_i  = 32'h100;
        c_wdata_i = 32'hA5A5_A5A5;
        c_sel_i   = 4'hF;
        ref_wr(32'h100, 32'hA5A5_A5A5, 4'hF);
        #1;
        chk("st_m_store", m_store_o, 1);
        chk("st_m_addr", m_addr_o, 32'h100);
        chk("st_m_wdata", m_wdata_o, 32'hA5A5_A5A5);
        chk("st_m_sel", {28'h0, m_sel_o}, 32'hF);
        chk("st_c_ready", c_ready_o, 1);
        cyc();
        c_store_i = 1'b0;
        #1;
        chk("st_ready_after", c_ready_o, 1);

        preload(32'h200, 32'h1234_5678);
        lat_lo = 3;
        lat_hi = 3;
        cyc();
        rv0 = core_rv;
        c_load_i = 1'b1;
        c_addr_i = 32'h200;
        core_q.push_back(32'h1234_5678);
        cyc();
        c_load_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ld_stall", c_ready_o, 0);
            cyc();
        end
        #1;
        chk("ld_ready_back", c_ready_o, 1);
        chk("ld_one_pulse", core_rv - rv0, 1);

        mem_drop = 1;
        cyc();
        rv0 = core_rv;
        c_load_i = 1'b1;
        c_addr_i = 32'h204;
        core_q.push_back(32'hFFFF_FFFF);
        cyc();
        c_load_i = 1'b0;
        repeat (70) cyc();
        chk("core_tmo_pulse", core_rv - rv0, 1);
        chk("core_tmo_ready", c_ready_o, 1);
        mem_drop = 0;

        lat_lo = 1;
        lat_hi = 1;
        c_load_i = 1'b1;
        c_addr_i = 32'h100;
        core_q.push_back(ref_rd(32'h100));
        cyc();
        c_load_i = 1'b0;
        repeat (4) cyc();

        preload(32'h300, 32'hCAFE_F00D);
        lat_lo = 2;
        lat_hi = 2;
        ak0 = ack_cnt;
        dbg_xact(0, 32'h300, 0, 4'hF, 0, 32'hCAFE_F00D, lat);
        chk("dbg_rd_latency", lat, 4);
        repeat (4) cyc();
        chk("dbg_one_ack", ack_cnt - ak0, 1);

        lat_lo = 1;
        lat_hi = 1;
        starve_round(32'h304, g);
        chk("starve_grants_1", g, SMAX);
        cyc();
        starve_round(32'h308, g);
        chk("starve_grants_2", g, SMAX);
        cyc();

        mem_drop = 1;
        dbg_xact(0, 32'h30C, 0, 4'hF, 1, 32'hFFFF_FFFF, lat);
        chk("dbg_tmo_latency", lat, TMO + 2);
        mem_drop = 0;
        cyc();
        #1;
        chk("dbg_tmo_idle", c_ready_o, 1);

        lat_lo = 6;
        lat_hi = 6;
        cyc();
        c_load_i = 1'b1;
        c_addr_i = 32'h200;
        cyc();
        c_load_i = 1'b0;
        cyc();
        rst_i = 1'b0;
        #1;
        chk("mid_rst_c_rvalid", c_rvalid_o, 0);
        chk("mid_rst_dbg_ack", dbg_ack_o, 0);
        chk("mid_rst_dbg_err", dbg_err_o, 0);
        chk("mid_rst_dbg_rdata", dbg_rdata_o, 0);
        chk("mid_rst_idle", c_ready_o, 1);
        cyc();
        rst_i = 1'b1;
        rv0 = core_rv;
        repeat (10) cyc();
        chk("late_rvalid_ignored", core_rv - rv0, 0);

        rnd_rdy = 1;
        lat_lo  = 1;
        lat_hi  = 5;
        dact    = 0;
        dwait   = 0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            c_load_i  = 1'b0;
            c_store_i = 1'b0;
            if (dact) begin
                if (dbg_acked) begin
                    chk("dbg_wait_bound", 32'(dwait <= BOUND), 1);
                    dbg_req_i = 1'b0;
                    dbg_acked = 0;
                    dact = 0;
                end else if (++dwait > BOUND) begin
                    chk("dbg_wait_bound", 0, 1);
                    dbg_req_i = 1'b0;
                    dact = 0;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                dbg_we_i    = 1'($urandom_range(0, 1));
                dbg_addr_i  = 32'h400 + 32'(4 * $urandom_range(0, 63));
                dbg_wdata_i = $urandom;
                dbg_sel_i   = 4'($urandom_range(1, 15));
                de.wr   = dbg_we_i;
                de.err  = 0;
                de.data = ref_rd(dbg_addr_i);
                if (dbg_we_i) ref_wr(dbg_addr_i, dbg_wdata_i, dbg_sel_i);
                dbg_q.push_back(de);
                dbg_acked = 0;
                dbg_req_i = 1'b1;
                dact  = 1;
                dwait = 0;
            end
            #1;
            if (c_ready_o) begin
                r = $urandom_range(0, 9);
                c_addr_i  = 32'(4 * $urandom_range(0, 63));
                c_wdata_i = $urandom;
                c_sel_i   = 4'($urandom_range(0, 15));
                if (r < 3) begin
                    c_store_i = 1'b1;
                    ref_wr(c_addr_i, c_wdata_i, c_sel_i);
                end else if (r < 5) begin
                    c_load_i = 1'b1;
                    core_q.push_back(ref_rd(c_addr_i));
                end
            end
        end
        cyc();
        c_load_i  = 1'b0;
        c_store_i = 1'b0;
        for (int i = 0; i < BOUND && dact; i++) begin
            cyc();
            if (dbg_acked) dact = 0;
        end
        if (dact) chk("dbg_drain_bound", 0, 1);
        dbg_req_i = 1'b0;
        repeat (20) cyc();
        chk("core_q_empty", core_q.size(), 0);
        chk("dbg_q_empty", dbg_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/kmkz_dmem_arbiter.md
Name: kmkz_dmem_arbiter

Overview:
Arbitrates the single data-memory bus between the execute stage's load/store port (core) and a debug-module memory master (dbg). Sits between urv_exec's dm_* interface and the external data memory. Core accesses pass through with zero added latency. Debug accesses are registered and sequenced by a small FSM. A starvation counter guarantees debug forward progress under continuous core traffic.

Parameters:
DBG_STARVE_MAX, 8, number of consecutive cycles a pending debug request may lose to the core before the core is blocked for one slot (range 1..255)
RD_TIMEOUT, 64, cycles to wait for m_rvalid_i before aborting a read (range 2..1023)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-low
c_addr_i  in  32  core address
c_wdata_i  in  32  core store data
c_sel_i  in  4  core byte select
c_load_i  in  1  core load strobe; asserted only while c_ready_o=1
c_store_i  in  1  core store strobe; asserted only while c_ready_o=1
c_ready_o  out  1  core may issue this cycle
c_rdata_o  out  32  core load data
c_rvalid_o  out  1  core load data valid, one-cycle pulse
dbg_req_i  in  1  debug request, level; held until dbg_ack_o
dbg_we_i  in  1  1 = write, 0 = read
dbg_addr_i  in  32  debug address
dbg_wdata_i  in  32  debug write data
dbg_sel_i  in  4  debug byte select
dbg_ack_o  out  1  debug completion pulse
dbg_rdata_o  out  32  debug read data, registered
dbg_err_o  out  1  qualifies dbg_ack_o: read timed out
m_addr_o  out  32  memory address
m_wdata_o  out  32  memory write data
m_sel_o  out  4  memory byte select
m_load_o  out  1  memory load strobe
m_store_o  out  1  memory store strobe
m_ready_i  in  1  memory accepts a strobe this cycle
m_rdata_i  in  32  memory read data
m_rvalid_i  in  1  read data valid; arrives at least 1 cycle after the accepted load

Behaviour:
- Reset: rst_i asynchronous, active-low; clock clk_i. All of the following clear to 0: state=IDLE, c_rvalid_o, dbg_ack_o, dbg_err_o, dbg_rdata_o, starve counter, timeout counter, latched debug request registers. Reset mid-transaction abandons it. A late m_rvalid_i arriving in IDLE is ignored.
- States: IDLE, CORE_RD, DBG_ISSUE, DBG_RD, DBG_DONE.
- Memory-side mux:
  - In IDLE, m_* are driven combinationally from c_*.
  - In DBG_ISSUE, m_* are driven from the latched debug registers.
  - m_load_o and m_store_o are 0 in all other states.
- c_ready_o = (state==IDLE) && m_ready_i && !force_dbg, where force_dbg = (starve_cnt==DBG_STARVE_MAX) && dbg_req_i.
- IDLE transitions:
  - Core store: accepted, one cycle, state stays IDLE.
  - Core load: go to CORE_RD.
  - Otherwise, if dbg_req_i is high and no core strobe is present: latch the dbg_* inputs and go to DBG_ISSUE.
  - Core wins any same-cycle conflict unless force_dbg is set.
- CORE_RD: wait for m_rvalid_i. On m_rvalid_i, c_rvalid_o=1 and c_rdata_o=m_rdata_i (both combinational), then return to IDLE.
- DBG_ISSUE: hold strobes until m_ready_i.
  - Write: go to DBG_DONE.
  - Read: go to DBG_RD.
- DBG_RD:
  - On m_rvalid_i: register m_rdata_i into dbg_rdata_o and go to DBG_DONE.
  - On timeout: dbg_rdata_o=32'hFFFFFFFF, set err, go to DBG_DONE.
- DBG_DONE: dbg_ack_o=1 for exactly one cycle, dbg_err_o valid in the same cycle; return to IDLE. The requester drops dbg_req_i in the cycle after the ack. Re-arbitration starts the following cycle.
- Starve counter:
  - Increments (saturating at DBG_STARVE_MAX) each IDLE cycle in which dbg_req_i=1 and a core strobe is accepted.
  - Clears when debug enters DBG_ISSUE.
- Timeout counter:
  - Clears on entry to CORE_RD or DBG_RD; increments every cycle in those states.
  - At RD_TIMEOUT-1 in CORE_RD: emit c_rvalid_o with c_rdata_o=32'hFFFFFFFF and return to IDLE.
- Single outstanding transaction at all times. No pipelining of back-to-back loads.
- m_ready_i low in IDLE: c_ready_o=0, so the exec stage stalls.

Decomposition:
- Shared package kmkz_defs.v additions: state encodings (ARB_IDLE..ARB_DBG_DONE, 3 bits) and the error read value 32'hFFFFFFFF (ARB_ERR_DATA).
- One natural sub-module: kmkz_arb_timeout, a loadable up-counter with a terminal-count flag, reused for both read waits.

Test Plan:
- Core store addr=0x100, data=0xA5A5A5A5, sel=4'hF, m_ready=1 -> m_store_o high in the same cycle with identical fields; state stays IDLE; c_ready_o stays 1.
- Core load addr=0x200, m_rvalid 3 cycles later with data 0x12345678 -> c_ready_o=0 for those 3 cycles; c_rvalid_o pulses once with 0x12345678.
- Debug read addr=0x300, memory returns 0xCAFEF00D after 2 cycles -> dbg_ack_o pulses once, dbg_rdata_o=0xCAFEF00D, dbg_err_o=0.
- Core stores issued every cycle while dbg_req_i is held (DBG_STARVE_MAX=8) -> after 8 core grants, c_ready_o=0 for one cycle and debug enters DBG_ISSUE; counter returns to 0.
- Debug read with m_rvalid never asserted (RD_TIMEOUT=64) -> ack at cycle 64 with dbg_err_o=1 and dbg_rdata_o=0xFFFFFFFF; state returns to IDLE.
- rst_i low while in CORE_RD, then m_rvalid_i pulses after release -> all outputs 0 and state IDLE; c_rvalid_o stays 0.
